// File: rtl/bnn_job_sequencer.sv
// Job sequencer for a bit-serial BNN classifier core: takes one feature vector at a
// time, runs the core for its fixed latency and returns the class index on a stream.
module bnn_job_sequencer #(
  parameter int N   = 11,
  parameter int B   = 4,
  parameter int M   = 40,
  parameter int C   = 6,
  parameter int LAT = N + M - 1,
  parameter int KW  = $clog2(C)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [B*N-1:0] in_data,
  output logic [B*N-1:0] core_data,
  output logic           core_rst,
  input  logic [KW-1:0]  core_klass,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [KW-1:0]  out_class,
  output logic           out_err,
  output logic           busy,
  output logic [15:0]    job_count
);

  localparam int CW = $clog2(LAT);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            last;
  logic            handshake;

  // Returns {err, class}; out-of-range klass codes map to class 0 with err set.
  function automatic logic [KW:0] klass_to_class(input logic [KW-1:0] k);
    if (int'(k) <= C - 1) return {1'b0, KW'(C - 1) - k};
    else                  return {1'b1, {KW{1'b0}}};
  endfunction

  assign accept    = (state == IDLE) && in_valid;
  assign last      = (state == RUN) && (cnt == CW'(LAT - 1));
  assign handshake = (state == DONE) && out_ready;
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = LOAD;
      LOAD:    state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // core_rst is registered from the next state so the core sees a clean flop output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      core_rst  <= 1'b1;
      core_data <= '0;
      out_class <= '0;
      out_err   <= 1'b0;
      job_count <= '0;
    end else begin
      state    <= state_nx;
      core_rst <= (state_nx != RUN);
      if (accept) core_data <= in_data;
      if (state == LOAD)     cnt <= '0;
      else if (state == RUN) cnt <= cnt + 1'b1;
      if (last) {out_err, out_class} <= klass_to_class(core_klass);
      if (handshake) job_count <= job_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_bnn_job_sequencer.sv
// Bench for bnn_job_sequencer with a stub core whose klass becomes valid only after
// the core's compute latency; results are checked through a scoreboard queue.
module tb_bnn_job_sequencer;

  localparam int N = 11, B = 4, M = 40, C = 6, LAT = N + M - 1, KW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [B*N-1:0]  in_data;
  logic [B*N-1:0]  core_data;
  logic            core_rst;
  logic [KW-1:0]   core_klass;
  logic            out_valid;
  logic            out_ready;
  logic [KW-1:0]   out_class;
  logic            out_err;
  logic            busy;
  logic [15:0]     job_count;

  bnn_job_sequencer #(.N(N), .B(B), .M(M), .C(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_data(core_data), .core_rst(core_rst), .core_klass(core_klass),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_err(out_err), .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ecount = 0;
  int acc;
  int nres = 0;
  logic [3:0] exp_q[$];

  always @(posedge clk) ecount <= ecount + 1;

  // Stub core: klass is garbage (7) until the core has run LAT-1 clocks out of reset.
  int         scnt = 0;
  logic       kmode = 1'b0;
  logic [2:0] kfix = 3'd0;

  function automatic logic [2:0] derive(input logic [B*N-1:0] d);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(d[4*i +: 4]);
    return 3'(s % 6);
  endfunction

  always @(posedge clk) begin
    if (core_rst) scnt <= 0;
    else if (scnt < 200) scnt <= scnt + 1;
  end

  always_comb begin
    core_klass = 3'd7;
    if (scnt >= LAT - 1) core_klass = kmode ? derive(core_data) : kfix;
  end

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: sampled after the input drive point and well before the next edge.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid && out_ready) begin
        nres++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got class %0d err %0d with empty queue", out_class, out_err);
        end else begin
          e = exp_q.pop_front();
          check("result", {out_err, out_class}, e);
        end
      end
    end
  end

  function automatic logic [3:0] expect_of(input logic [2:0] k);
    if (k <= 3'd5) return {1'b0, 3'd5 - k};
    else           return 4'b1000;
  endfunction

  task automatic start_job(input logic [B*N-1:0] d);
    int t = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", (t < 300) ? 1 : 0, 1);
    exp_q.push_back(expect_of(kmode ? derive(d) : kfix));
    @(negedge clk);
    acc = ecount;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output int low);
    lat = -1;
    low = 0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin
        lat = ecount - acc;
        break;
      end
      if (!core_rst) low++;
      @(negedge clk);
    end
  endtask

  logic [B*N-1:0] vec[5] = '{44'h46012229a22, 44'h58022538633, 44'h57122338733,
                             44'h92912439523, 44'h46012229a22};

  initial begin
    int lat, low, jc, cnt_bad, seen, t;
    int ae[3];
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_in_rst", in_ready, 0);
    @(negedge clk);
    check("rst_core_rst", core_rst, 1);
    check("rst_core_data", core_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_class", {out_err, out_class}, 0);
    check("rst_job_count", job_count, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // Abort mid-RUN at cnt=25 (negedge after accept edge +26)
    kmode = 1'b0; kfix = 3'd2;
    start_job(44'h46012229a22);
    repeat (26) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_core_rst", core_rst, 1);
    check("abort_busy", busy, 0);
    exp_q.delete();
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    check("abort_job_count", job_count, 0);

    // Single job, klass=2 -> class 3
    start_job(44'h46012229a22);
    check("core_data_latch", core_data, 44'h46012229a22);
    wait_result(lat, low);
    check("latency", lat, LAT + 1);
    check("core_rst_low", low, LAT);
    @(negedge clk);
    check("job_count_1", job_count, 1);
    check("in_ready_after", in_ready, 1);

    // Five vectors through a data-dependent klass
    kmode = 1'b1;
    for (int j = 0; j < 5; j++) begin
      start_job(vec[j]);
      wait_result(lat, low);
      check("vec_latency", lat, LAT + 1);
      @(negedge clk);
    end
    check("job_count_6", job_count, 6);

    // Backpressure: klass=4 -> class 1
    kmode = 1'b0; kfix = 3'd4; out_ready = 1'b0;
    start_job(44'h92912439523);
    wait_result(lat, low);
    check("bp_latency", lat, LAT + 1);
    cnt_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || out_class != 3'd1 || core_data != 44'h92912439523 || in_ready || !core_rst)
        cnt_bad++;
    end
    check("bp_hold", cnt_bad, 0);
    jc = nres;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready", in_ready, 1);
    check("bp_out_valid", out_valid, 0);
    check("bp_job_count", job_count, 7);
    check("bp_one_handshake", nres - jc, 1);

    // Out-of-range klass values
    kfix = 3'd6;
    start_job(44'h58022538633);
    wait_result(lat, low);
    check("err6_flag", {out_err, out_class}, 4'b1000);
    @(negedge clk);
    kfix = 3'd7;
    start_job(44'h57122338733);
    wait_result(lat, low);
    check("err7_flag", {out_err, out_class}, 4'b1000);
    @(negedge clk);

    // Back-to-back with in_valid held high
    kfix = 3'd1;
    jc = job_count;
    in_data = 44'h57122338733;
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      t = 0;
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      exp_q.push_back(expect_of(kfix));
      ae[j] = ecount;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_gap1", ae[1] - ae[0], LAT + 3);
    check("b2b_gap2", ae[2] - ae[1], LAT + 3);
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("b2b_job_count", job_count - jc, 3);

    // Counter wrap
    force dut.job_count = 16'hFFFF;
    @(negedge clk);
    release dut.job_count;
    @(negedge clk);
    check("wrap_preload", job_count, 16'hFFFF);
    kfix = 3'd0;
    start_job(44'h46012229a22);
    wait_result(lat, low);
    @(negedge clk);
    check("wrap_zero", job_count, 16'h0000);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
